// File: rtl/subleq_input_output_ports.sv
// Memory-mapped write path for the SUBLEQ core: one address drives an 8-bit output port and every
// other address goes to a 256 x 8 data RAM. Read data for the current address is returned one edge later.
module subleq_input_output_ports #(
    parameter logic [7:0] IO_ADDR = 8'd0,
    parameter int         DEPTH   = 256
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] addrWrite,
    input  logic [7:0] dataWrite,
    input  logic       WE,
    output logic [7:0] out_port,
    output logic [7:0] out_ram
);

    logic [7:0] mem [DEPTH];
    logic [7:0] ram_rd_q;

    logic [7:0]       out_port_q, out_port_d;
    logic [7:0]       byp_q, byp_d;
    logic             use_ram_q, use_ram_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic sel_port;
    logic wr_ram;

    assign sel_port = (addrWrite == IO_ADDR);
    assign wr_ram   = WE && !sel_port && !RST;

    always_comb begin
        out_port_d = out_port_q;
        if (WE && sel_port) begin
            out_port_d = dataWrite;
        end
    end

    // A RAM word reads back as zero until written after the last reset, so clearing the
    // valid bits stands in for zeroing every word while the array itself stays resetless.
    always_comb begin
        valid_d = valid_q;
        if (WE && !sel_port) begin
            valid_d[addrWrite] = 1'b1;
        end
    end

    // The read port returns the pre-write word; writes and port reads are served from the bypass.
    always_comb begin
        byp_d     = 8'h00;
        use_ram_d = 1'b0;
        if (sel_port) begin
            byp_d = out_port_d;
        end else if (WE) begin
            byp_d = dataWrite;
        end else begin
            use_ram_d = valid_q[addrWrite];
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_ram) begin
            mem[addrWrite] <= dataWrite;
        end
        ram_rd_q <= mem[addrWrite];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_port_q <= 8'h00;
            byp_q      <= 8'h00;
            use_ram_q  <= 1'b0;
            valid_q    <= '0;
        end else begin
            out_port_q <= out_port_d;
            byp_q      <= byp_d;
            use_ram_q  <= use_ram_d;
            valid_q    <= valid_d;
        end
    end

    assign out_port = out_port_q;
    assign out_ram  = use_ram_q ? ram_rd_q : byp_q;

endmodule

// File: tb/tb_subleq_input_output_ports.sv
// Self-checking bench: directed scenarios plus randomized traffic compared against a plain
// array-and-register model of the memory map.
module tb_subleq_input_output_ports;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] out_port;
    logic [7:0] out_ram;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0] model_mem [256];
    logic [7:0] model_port;
    logic [7:0] model_ram_out;

    subleq_input_output_ports #(
        .IO_ADDR(8'd0),
        .DEPTH  (256)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .addrWrite(addr),
        .dataWrite(wdata),
        .WE       (we),
        .out_port (out_port),
        .out_ram  (out_ram)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs, update the model from the memory-map rules, compare both outputs.
    task automatic step(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        rst   = r;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        if (r) begin
            model_port = 8'h00;
            for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
            model_ram_out = 8'h00;
        end else if (a == 8'd0) begin
            if (w) model_port = d;
            model_ram_out = model_port;
        end else begin
            if (w) model_mem[a] = d;
            model_ram_out = model_mem[a];
        end
        #1;
        $display("txn rst=%0b we=%0b addr=%3d data=%02h -> port=%02h ram=%02h", r, w, a, d, out_port, out_ram);
        check("out_port", out_port, model_port);
        check("out_ram", out_ram, model_ram_out);
    endtask

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        addr  = 8'd0;
        wdata = 8'd0;
        model_port    = 8'h00;
        model_ram_out = 8'h00;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        // Reset, then idle with stray address/data
        step(1'b1, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd44, 8'd125);
        check("mem44_after_idle", out_ram, 8'h00);

        // Port write and readback
        step(1'b0, 1'b1, 8'd0, 8'd125);
        check("port_write_port", out_port, 8'd125);
        check("port_write_ram", out_ram, 8'd125);
        step(1'b0, 1'b0, 8'd0, 8'd0);
        check("port_readback", out_ram, 8'd125);

        // RAM write, write-through, readback, neighbour untouched
        step(1'b0, 1'b1, 8'd123, 8'd125);
        check("ram_write_through", out_ram, 8'd125);
        check("port_held", out_port, 8'd125);
        step(1'b0, 1'b0, 8'd123, 8'd0);
        check("ram123_readback", out_ram, 8'd125);
        step(1'b0, 1'b0, 8'd122, 8'd0);
        check("ram122_zero", out_ram, 8'h00);

        // Back-to-back mixed writes, including the top address
        step(1'b0, 1'b1, 8'd1, 8'hAA);
        step(1'b0, 1'b1, 8'd255, 8'h55);
        step(1'b0, 1'b1, 8'd0, 8'h0F);
        check("b2b_port", out_port, 8'h0F);
        step(1'b0, 1'b0, 8'd1, 8'd0);
        check("b2b_ram1", out_ram, 8'hAA);
        step(1'b0, 1'b0, 8'd255, 8'd0);
        check("b2b_ram255", out_ram, 8'h55);

        // Reset beats a simultaneous port write and clears RAM
        step(1'b1, 1'b1, 8'd0, 8'hFF);
        check("rst_port", out_port, 8'h00);
        check("rst_ram", out_ram, 8'h00);
        step(1'b0, 1'b0, 8'd1, 8'd0);
        check("rst_ram1", out_ram, 8'h00);
        step(1'b0, 1'b0, 8'd123, 8'd0);
        check("rst_ram123", out_ram, 8'h00);

        // Write then hold the address with WE low
        step(1'b0, 1'b1, 8'd5, 8'h33);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'd5, 8'($urandom));
            check("hold_ram5", out_ram, 8'h33);
            check("hold_port", out_port, 8'h00);
        end

        // Randomized traffic biased toward a few addresses so reads hit earlier writes
        for (int n = 0; n < 600; n++) begin
            logic       r, w;
            logic [7:0] a, d;
            int         sel;
            r   = ($urandom_range(0, 59) == 0);
            w   = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 3);
            if (sel == 0)      a = 8'd0;
            else if (sel == 1) a = 8'($urandom_range(1, 6));
            else if (sel == 2) a = 8'($urandom_range(250, 255));
            else               a = 8'($urandom);
            d = 8'($urandom);
            step(r, w, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
